// File: rtl/cfu_gcd_li3_pkg.sv
// Shared constants and engine state encoding for the level-3 multi-engine CFU GCD unit.
package cfu_gcd_li3_pkg;

  localparam int unsigned CFU_GCD_FUNC_GCD         = 0;
  localparam int unsigned CFU_ERR_UNSUPPORTED_FUNC = 1;

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StRun  = 2'd1,
    StDone = 2'd2
  } eng_state_e;

  // Index width for a set of n engines; never narrower than one bit.
  function automatic int unsigned ptr_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/cfu_gcd_li3_engine.sv
// One GCD engine: IDLE -> RUN -> DONE -> IDLE. Subtractive core by default; binary (Stein)
// core when CFU_GCD_BINARY_EN is defined.
module cfu_gcd_li3_engine
  import cfu_gcd_li3_pkg::*;
#(
  parameter int unsigned CFU_FUNC_ID_W     = 1,
  parameter int unsigned CFU_REQ_RESP_ID_W = 8,
  parameter int unsigned CFU_DATA_W        = 32
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         start,
  input  logic [CFU_FUNC_ID_W-1:0]     func,
  input  logic [CFU_REQ_RESP_ID_W-1:0] id,
  input  logic [CFU_DATA_W-1:0]        a_in,
  input  logic [CFU_DATA_W-1:0]        b_in,
  input  logic                         grant,
  output logic                         idle,
  output logic                         done,
  output logic [CFU_REQ_RESP_ID_W-1:0] res_id,
  output logic [CFU_DATA_W-1:0]        res_data,
  output logic                         res_err
);

  eng_state_e                   state_q, state_d;
  logic [CFU_DATA_W-1:0]        a_q, a_d, b_q, b_d, res_q, fin_val;
  logic [CFU_REQ_RESP_ID_W-1:0] id_q;
  logic                         err_q;
  logic                         fin;
  logic                         is_gcd;

  assign is_gcd = (func == CFU_FUNC_ID_W'(CFU_GCD_FUNC_GCD));

`ifdef CFU_GCD_BINARY_EN
  localparam int unsigned KW = $clog2(CFU_DATA_W) + 1;

  logic [KW-1:0] k_q, k_d;
  logic          strip_q, strip_d;  // set once the common factors of two are removed

  always_comb begin
    a_d     = a_q;
    b_d     = b_q;
    k_d     = k_q;
    strip_d = strip_q;
    fin     = 1'b0;
    fin_val = '0;
    if (a_q == '0) begin
      fin     = 1'b1;
      fin_val = b_q << k_q;
    end else if (!strip_q) begin
      if (b_q == '0) begin
        fin     = 1'b1;
        fin_val = a_q << k_q;
      end else if (!a_q[0] && !b_q[0]) begin
        a_d = a_q >> 1;
        b_d = b_q >> 1;
        k_d = k_q + KW'(1);
      end else begin
        strip_d = 1'b1;
      end
    end else if (!a_q[0]) begin
      a_d = a_q >> 1;
    end else if (!b_q[0]) begin
      b_d = b_q >> 1;
    end else if (a_q >= b_q) begin
      a_d = a_q - b_q;
    end else begin
      a_d = b_q - a_q;
      b_d = a_q;
    end
  end

  always_ff @(posedge clk) begin
    if (rst || state_q == StIdle) begin
      k_q     <= '0;
      strip_q <= 1'b0;
    end else if (state_q == StRun) begin
      k_q     <= k_d;
      strip_q <= strip_d;
    end
  end
`else
  always_comb begin
    a_d     = a_q;
    b_d     = b_q;
    fin     = 1'b0;
    fin_val = a_q;
    if (a_q < b_q) begin
      a_d = b_q;
      b_d = a_q;
    end else if (b_q != '0) begin
      a_d = a_q - b_q;
    end else begin
      fin = 1'b1;
    end
  end
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      StIdle:  if (start) state_d = is_gcd ? StRun : StDone;
      StRun:   if (fin) state_d = StDone;
      StDone:  if (grant) state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    idle     = (state_q == StIdle);
    done     = (state_q == StDone);
    res_id   = id_q;
    res_data = res_q;
    res_err  = err_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      a_q   <= '0;
      b_q   <= '0;
      id_q  <= '0;
      err_q <= 1'b0;
      res_q <= '0;
    end else if (state_q == StIdle && start) begin
      a_q   <= a_in;
      b_q   <= b_in;
      id_q  <= id;
      err_q <= !is_gcd;
      res_q <= '0;
    end else if (state_q == StRun) begin
      a_q <= a_d;
      b_q <= b_d;
      if (fin) res_q <= fin_val;
    end
  end

endmodule

// File: rtl/cfu_gcd_li3.sv
// Level-3 CFU GCD unit: N_ENG engines, lowest-idle dispatch, round-robin response arbitration
// and a back-pressured response register. CFU_GCD_BINARY_EN selects the binary GCD core.
module cfu_gcd_li3
  import cfu_gcd_li3_pkg::*;
#(
  parameter int unsigned CFU_FUNC_ID_W     = 1,
  parameter int unsigned CFU_REQ_RESP_ID_W = 8,
  parameter int unsigned CFU_DATA_W        = 32,
  parameter int unsigned CFU_ERR_ID_W      = 32,
  parameter int unsigned N_ENG             = 4
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         req_valid,
  output logic                         req_ready,
  input  logic [CFU_FUNC_ID_W-1:0]     req_func_id,
  input  logic [CFU_REQ_RESP_ID_W-1:0] req_id,
  input  logic [CFU_DATA_W-1:0]        req_data0,
  input  logic [CFU_DATA_W-1:0]        req_data1,
  output logic                         resp_valid,
  input  logic                         resp_ready,
  output logic [CFU_REQ_RESP_ID_W-1:0] resp_id,
  output logic [CFU_DATA_W-1:0]        resp_data,
  output logic                         resp_err,
  output logic [CFU_ERR_ID_W-1:0]      resp_err_id
);

  localparam int unsigned PtrW = ptr_width(N_ENG);

  logic [N_ENG-1:0]             eng_idle, eng_done, eng_start, eng_grant, eng_err;
  logic [CFU_REQ_RESP_ID_W-1:0] eng_id   [N_ENG];
  logic [CFU_DATA_W-1:0]        eng_data [N_ENG];

  logic            accept, load, win_any;
  logic [PtrW-1:0] rr_q, win_idx, rr_next, arb_idx;
  logic [PtrW:0]   arb_sum;

  logic                         resp_valid_q, resp_err_q;
  logic [CFU_REQ_RESP_ID_W-1:0] resp_id_q;
  logic [CFU_DATA_W-1:0]        resp_data_q;
  logic [CFU_ERR_ID_W-1:0]      resp_err_id_q;

  // Registered idle flags only, so a just-freed engine waits one cycle before reuse.
  assign req_ready = |eng_idle;
  assign accept    = req_valid && req_ready;
  assign load      = !resp_valid_q || resp_ready;

  // Descending scan so the lowest-index idle engine wins.
  always_comb begin
    eng_start = '0;
    for (int i = int'(N_ENG) - 1; i >= 0; i--) begin
      if (eng_idle[i]) begin
        eng_start    = '0;
        eng_start[i] = accept;
      end
    end
  end

  always_comb begin
    win_any = 1'b0;
    win_idx = '0;
    arb_sum = '0;
    arb_idx = '0;
    for (int off = 0; off < int'(N_ENG); off++) begin
      arb_sum = {1'b0, rr_q} + (PtrW+1)'(off);
      if (arb_sum >= (PtrW+1)'(N_ENG)) arb_sum = arb_sum - (PtrW+1)'(N_ENG);
      arb_idx = arb_sum[PtrW-1:0];
      if (!win_any && eng_done[arb_idx]) begin
        win_any = 1'b1;
        win_idx = arb_idx;
      end
    end
  end

  assign rr_next = (win_idx == PtrW'(N_ENG - 1)) ? '0 : win_idx + PtrW'(1);

  always_comb begin
    eng_grant = '0;
    if (load && win_any) eng_grant[win_idx] = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      resp_valid_q  <= 1'b0;
      resp_id_q     <= '0;
      resp_data_q   <= '0;
      resp_err_q    <= 1'b0;
      resp_err_id_q <= '0;
      rr_q          <= '0;
    end else if (load) begin
      resp_valid_q <= win_any;
      if (win_any) begin
        resp_id_q     <= eng_id[win_idx];
        resp_data_q   <= eng_data[win_idx];
        resp_err_q    <= eng_err[win_idx];
        resp_err_id_q <= eng_err[win_idx] ? CFU_ERR_ID_W'(CFU_ERR_UNSUPPORTED_FUNC) : '0;
        rr_q          <= rr_next;
      end
    end
  end

  assign resp_valid  = resp_valid_q;
  assign resp_id     = resp_id_q;
  assign resp_data   = resp_data_q;
  assign resp_err    = resp_err_q;
  assign resp_err_id = resp_err_id_q;

  for (genvar g = 0; g < N_ENG; g++) begin : g_eng
    cfu_gcd_li3_engine #(
      .CFU_FUNC_ID_W    (CFU_FUNC_ID_W),
      .CFU_REQ_RESP_ID_W(CFU_REQ_RESP_ID_W),
      .CFU_DATA_W       (CFU_DATA_W)
    ) u_eng (
      .clk     (clk),
      .rst     (rst),
      .start   (eng_start[g]),
      .func    (req_func_id),
      .id      (req_id),
      .a_in    (req_data0),
      .b_in    (req_data1),
      .grant   (eng_grant[g]),
      .idle    (eng_idle[g]),
      .done    (eng_done[g]),
      .res_id  (eng_id[g]),
      .res_data(eng_data[g]),
      .res_err (eng_err[g])
    );
  end

endmodule

// File: tb/tb_cfu_gcd_li3.sv
// Scoreboard bench for cfu_gcd_li3: tag-keyed expectations checked by an independent monitor.
module tb_cfu_gcd_li3;

  localparam int unsigned FW = 1;
  localparam int unsigned IW = 8;
  localparam int unsigned DW = 32;
  localparam int unsigned EW = 32;
  localparam int unsigned NE = 4;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          req_valid = 1'b0;
  logic          req_ready;
  logic [FW-1:0] req_func_id = '0;
  logic [IW-1:0] req_id = '0;
  logic [DW-1:0] req_data0 = '0;
  logic [DW-1:0] req_data1 = '0;
  logic          resp_valid;
  logic          resp_ready = 1'b0;
  logic [IW-1:0] resp_id;
  logic [DW-1:0] resp_data;
  logic          resp_err;
  logic [EW-1:0] resp_err_id;

  always #5 clk = ~clk;

  cfu_gcd_li3 #(
    .CFU_FUNC_ID_W    (FW),
    .CFU_REQ_RESP_ID_W(IW),
    .CFU_DATA_W       (DW),
    .CFU_ERR_ID_W     (EW),
    .N_ENG            (NE)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_func_id(req_func_id),
    .req_id     (req_id),
    .req_data0  (req_data0),
    .req_data1  (req_data1),
    .resp_valid (resp_valid),
    .resp_ready (resp_ready),
    .resp_id    (resp_id),
    .resp_data  (resp_data),
    .resp_err   (resp_err),
    .resp_err_id(resp_err_id)
  );

  typedef struct {
    logic [IW-1:0] id;
    logic [DW-1:0] data;
    logic          err;
    logic [EW-1:0] err_id;
  } exp_t;

  exp_t          sb[$];
  logic [IW-1:0] got_id[$];
  logic [DW-1:0] got_data[$];
  int unsigned   got_cyc[$];
  int unsigned   checks = 0;
  int unsigned   errors = 0;
  int unsigned   cyc = 0;
  logic          rand_ready = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  // Euclid by remainder; gcd(x,0)=x and gcd(0,0)=0 fall out naturally.
  function automatic logic [DW-1:0] ref_gcd(input logic [DW-1:0] x, input logic [DW-1:0] y);
    logic [DW-1:0] t;
    while (y != 0) begin
      t = x % y;
      x = y;
      y = t;
    end
    return x;
  endfunction

  // Called at posedge+1; returns at posedge+1 after the accepting edge.
  task automatic send(input logic [FW-1:0] f, input logic [IW-1:0] id,
                      input logic [DW-1:0] a, input logic [DW-1:0] b);
    exp_t        e;
    int unsigned n;
    logic        ok;
    n  = 0;
    ok = 1'b0;
    req_valid = 1'b1;
    req_func_id = f;
    req_id = id;
    req_data0 = a;
    req_data1 = b;
    forever begin
      @(negedge clk);
      if (req_ready) begin
        ok = 1'b1;
        break;
      end
      n++;
      if (n > 5000) begin
        checks++;
        errors++;
        $display("FAIL req_timeout: got no accept for id %0d want accept", id);
        break;
      end
      @(posedge clk);
      #1;
    end
    if (ok) begin
      e.id     = id;
      e.err    = (f != '0);
      e.data   = e.err ? '0 : ref_gcd(a, b);
      e.err_id = e.err ? EW'(1) : '0;
      sb.push_back(e);
    end
    @(posedge clk);
    #1;
    req_valid = 1'b0;
  endtask

  task automatic drain(input string name, input int unsigned bound);
    int unsigned n;
    n = 0;
    while (sb.size() != 0 && n < bound) begin
      @(posedge clk);
      n++;
    end
    check({name, "_drain"}, 64'(sb.size()), 64'd0);
    repeat (2) @(posedge clk);
    #1;
  endtask

  initial begin : monitor
    int idx;
    forever begin
      @(negedge clk);
      if (!rst && resp_valid && resp_ready) begin
        idx = -1;
        for (int i = 0; i < sb.size(); i++) if (idx < 0 && sb[i].id == resp_id) idx = i;
        got_id.push_back(resp_id);
        got_data.push_back(resp_data);
        got_cyc.push_back(cyc);
        if (idx < 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_tag: got id %0d want an outstanding tag", resp_id);
        end else begin
          check("resp_data", 64'(resp_data), 64'(sb[idx].data));
          check("resp_err", 64'(resp_err), 64'(sb[idx].err));
          check("resp_err_id", 64'(resp_err_id), 64'(sb[idx].err_id));
          sb.delete(idx);
        end
      end
    end
  end

  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (rand_ready) resp_ready = ($urandom_range(0, 3) != 0);
    end
  end

  initial begin
    #900_000;
    $display("FAIL watchdog: got timeout want completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int unsigned base;
    logic [FW-1:0] f;
    logic [DW-1:0] a, b, g;

    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("rst_req_ready", 64'(req_ready), 64'd1);
    check("rst_resp_valid", 64'(resp_valid), 64'd0);
    check("rst_resp_id", 64'(resp_id), 64'd0);
    check("rst_resp_data", 64'(resp_data), 64'd0);
    check("rst_resp_err", 64'(resp_err), 64'd0);
    check("rst_resp_err_id", 64'(resp_err_id), 64'd0);

    @(posedge clk);
    #1 resp_ready = 1'b1;
    send('0, 8'd5, 32'd12, 32'd18);
    drain("g12_18", 200);
    check("g12_18_id", 64'(got_id[$]), 64'd5);
    check("g12_18_val", 64'(got_data[$]), 64'd6);
    send('0, 8'd6, 32'd0, 32'd7);
    drain("g0_7", 200);
    check("g0_7_val", 64'(got_data[$]), 64'd7);
    send('0, 8'd7, 32'd0, 32'd0);
    drain("g0_0", 200);
    check("g0_0_val", 64'(got_data[$]), 64'd0);

    // Fill every engine; the short (9,9) job overtakes the others.
    base = got_id.size();
    send('0, 8'd1, 32'd1000, 32'd1);
    send('0, 8'd2, 32'd6, 32'd4);
    send('0, 8'd3, 32'd9, 32'd9);
    send('0, 8'd4, 32'd35, 32'd14);
    @(negedge clk);
    check("fill_ready_low", 64'(req_ready), 64'd0);
    drain("fill", 3000);
    check("fill_count", 64'(got_id.size() - base), 64'd4);
    check("fill_first_id", 64'(got_id[base]), 64'd3);

    send(FW'(1), 8'd9, 32'd123, 32'd456);
    drain("err", 200);
    check("err_id_tag", 64'(got_id[$]), 64'd9);
    check("err_data", 64'(got_data[$]), 64'd0);

    // Back-pressure: id 11 finishes first and must sit in the response register.
    resp_ready = 1'b0;
    base = got_id.size();
    send('0, 8'd10, 32'd6, 32'd4);
    send('0, 8'd11, 32'd9, 32'd9);
    repeat (12) @(posedge clk);
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      check("bp_valid", 64'(resp_valid), 64'd1);
      check("bp_id", 64'(resp_id), 64'd11);
      check("bp_data", 64'(resp_data), 64'd9);
    end
    @(posedge clk);
    #1 resp_ready = 1'b1;
    drain("bp", 100);
    check("bp_count", 64'(got_id.size() - base), 64'd2);
    check("bp_first", 64'(got_id[base]), 64'd11);
    check("bp_second", 64'(got_id[base+1]), 64'd10);
    check("bp_consecutive", 64'(got_cyc[base+1] - got_cyc[base]), 64'd1);

    // Reset mid-operation drops the in-flight request silently.
    send('0, 8'd77, 32'd1000, 32'd1);
    repeat (10) @(posedge clk);
    #1 rst = 1'b1;
    sb.delete();
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("midrst_req_ready", 64'(req_ready), 64'd1);
    check("midrst_resp_valid", 64'(resp_valid), 64'd0);
    base = got_id.size();
    repeat (1100) @(posedge clk);
    #1;
    check("midrst_no_resp", 64'(got_id.size() - base), 64'd0);

    rand_ready = 1'b1;
    for (int i = 0; i < 2000; i++) begin
      repeat ($urandom_range(0, 2)) begin
        @(posedge clk);
        #1;
      end
      f = ($urandom_range(0, 15) == 0) ? FW'(1) : FW'(0);
      if ($urandom_range(0, 1) == 0) begin
        g = DW'($urandom_range(1, 12));
        a = g * DW'($urandom_range(0, 20));
        b = g * DW'($urandom_range(0, 20));
      end else begin
        a = DW'($urandom_range(0, 255));
        b = DW'($urandom_range(0, 255));
      end
      send(f, IW'(i + 100), a, b);
    end
    rand_ready = 1'b0;
    @(posedge clk);
    #2 resp_ready = 1'b1;
    drain("random", 3000);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
